// File: rtl/ecc_montmul_seq.sv
// Word-serial Montgomery multiplier: result = a*b*R^-1 mod p, R = 2^(RADIX*NWORDS).
// One RADIX x RADIX multiply-accumulate step per cycle, with fold, final subtract and handshake.
module ecc_montmul_seq #(
    parameter int RADIX  = 32,
    parameter int NWORDS = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    zeroize,
    input  logic                    start,
    input  logic [RADIX*NWORDS-1:0] a_in,
    input  logic [RADIX*NWORDS-1:0] b_in,
    input  logic [RADIX*NWORDS-1:0] p_in,
    input  logic [RADIX-1:0]        n_prime_in,
    output logic                    ready,
    output logic                    valid_out,
    output logic [RADIX*NWORDS-1:0] result
);

    localparam int W  = RADIX * NWORDS;
    localparam int W2 = 2 * RADIX;
    localparam int DW = 2 * RADIX + 1;
    localparam int CW = RADIX + 1;
    localparam int JW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [JW-1:0] LAST = JW'(NWORDS - 1);

    typedef enum logic [2:0] {IDLE, MULT, FOLD, SUB, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              clear;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      p_q;
    logic [RADIX-1:0]  n_q;
    logic [RADIX-1:0]  t_q [NWORDS];
    logic [RADIX-1:0]  d_q [NWORDS];
    logic              t_top;
    logic [CW-1:0]     c_q;
    logic [RADIX-1:0]  m_q;
    logic              borrow_q;
    logic [JW-1:0]     i_q;
    logic [JW-1:0]     j_q;
    logic              j_last;
    logic              i_last;
    logic              first;
    logic [RADIX-1:0]  a_w;
    logic [RADIX-1:0]  b_w;
    logic [RADIX-1:0]  p_w;
    logic [RADIX-1:0]  t_w;
    logic [W2-1:0]     ab;
    logic [RADIX-1:0]  q_w;
    logic [RADIX-1:0]  m_new;
    logic [RADIX-1:0]  m_w;
    logic [DW-1:0]     res;
    logic [CW-1:0]     fsum;
    logic              b_in_w;
    logic [CW-1:0]     diff;
    logic [W-1:0]      t_flat;
    logic [W-1:0]      d_flat;

    assign clear  = ~reset_n | zeroize;
    assign ready  = (state == IDLE);
    assign j_last = (j_q == LAST);
    assign i_last = (i_q == LAST);
    assign first  = (j_q == '0);

    // Word select, quotient digit, MAC step, fold and subtract datapath.
    always_comb begin
        a_w    = a_q[int'(j_q)*RADIX +: RADIX];
        b_w    = b_q[int'(i_q)*RADIX +: RADIX];
        p_w    = p_q[int'(j_q)*RADIX +: RADIX];
        t_w    = t_q[j_q];
        ab     = W2'(a_w) * W2'(b_w);
        q_w    = t_q[0] + ab[RADIX-1:0];
        m_new  = q_w * n_q;
        m_w    = first ? m_new : m_q;
        res    = DW'(ab) + DW'(W2'(m_w) * W2'(p_w)) + DW'(t_w)
               + (first ? DW'(0) : DW'(c_q));
        fsum   = CW'(t_top) + c_q;
        b_in_w = first ? 1'b0 : borrow_q;
        diff   = CW'(t_w) - CW'(p_w) - CW'(b_in_w);
        for (int k = 0; k < NWORDS; k++) begin
            t_flat[k*RADIX +: RADIX] = t_q[k];
            d_flat[k*RADIX +: RADIX] = (k == NWORDS - 1) ? diff[RADIX-1:0] : d_q[k];
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state sequencing: rows of MULT+FOLD, then SUB, then one DONE cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = MULT;
            MULT:    if (j_last) state_nxt = FOLD;
            FOLD:    state_nxt = i_last ? SUB : MULT;
            SUB:     if (j_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, accumulator update, counters and result register.
    always_ff @(posedge clk) begin
        if (clear) begin
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            n_q       <= '0;
            for (int k = 0; k < NWORDS; k++) begin
                t_q[k] <= '0;
                d_q[k] <= '0;
            end
            t_top     <= 1'b0;
            c_q       <= '0;
            m_q       <= '0;
            borrow_q  <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            valid_out <= 1'b0;
            result    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        p_q   <= p_in;
                        n_q   <= n_prime_in;
                        for (int k = 0; k < NWORDS; k++) t_q[k] <= '0;
                        t_top <= 1'b0;
                        c_q   <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                MULT: begin
                    if (first) m_q <= m_new;
                    else       t_q[j_q - 1'b1] <= res[RADIX-1:0];
                    c_q <= res[DW-1:RADIX];
                    j_q <= j_last ? '0 : j_q + 1'b1;
                end
                FOLD: begin
                    {t_top, t_q[NWORDS-1]} <= fsum;
                    if (!i_last) i_q <= i_q + 1'b1;
                    borrow_q <= 1'b0;
                end
                SUB: begin
                    d_q[j_q] <= diff[RADIX-1:0];
                    borrow_q <= diff[RADIX];
                    j_q      <= j_last ? '0 : j_q + 1'b1;
                    if (j_last) begin
                        valid_out <= 1'b1;
                        result    <= (t_top | ~diff[RADIX]) ? d_flat : t_flat;
                    end
                end
                DONE:    valid_out <= 1'b0;
                default: valid_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_montmul_seq.sv
// Bench for ecc_montmul_seq: small (8x2) instance against a cycle model,
// plus a 32x8 instance for wide operands and latency.
module tb_ecc_montmul_seq;

    localparam int R1   = 8;
    localparam int N1   = 2;
    localparam int W1   = R1 * N1;
    localparam int LAT1 = N1 * (N1 + 1) + N1 + 1;
    localparam int R2   = 32;
    localparam int N2   = 8;
    localparam int W2   = R2 * N2;
    localparam int LAT2 = 81;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          zeroize;
    logic          start;
    logic [W1-1:0] a;
    logic [W1-1:0] b;
    logic [W1-1:0] p;
    logic [R1-1:0] np;
    logic          ready;
    logic          valid;
    logic [W1-1:0] result;

    logic          zeroize2;
    logic          start2;
    logic [W2-1:0] a2;
    logic [W2-1:0] b2;
    logic [W2-1:0] p2;
    logic [R2-1:0] np2;
    logic          ready2;
    logic          valid2;
    logic [W2-1:0] result2;

    int total  = 0;
    int passed = 0;
    bit check_en = 1'b0;

    logic         m_busy  = 1'b0;
    logic         m_valid = 1'b0;
    int           m_cnt   = 0;
    logic [255:0] m_res   = '0;
    logic [255:0] m_pend  = '0;

    ecc_montmul_seq #(.RADIX(R1), .NWORDS(N1)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start(start),
        .a_in(a), .b_in(b), .p_in(p), .n_prime_in(np),
        .ready(ready), .valid_out(valid), .result(result)
    );

    ecc_montmul_seq #(.RADIX(R2), .NWORDS(N2)) dut2 (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize2), .start(start2),
        .a_in(a2), .b_in(b2), .p_in(p2), .n_prime_in(np2),
        .ready(ready2), .valid_out(valid2), .result(result2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Bit-serial Montgomery reduction: a*b*2^-nbits mod p.
    function automatic logic [255:0] mont(input logic [255:0] xa, input logic [255:0] xb,
                                          input logic [255:0] xp, input int nbits);
        logic [511:0] x;
        x = {256'b0, xa} * {256'b0, xb};
        for (int k = 0; k < nbits; k++) begin
            if (x[0]) x = x + {256'b0, xp};
            x = x >> 1;
        end
        if (x >= {256'b0, xp}) x = x - {256'b0, xp};
        return x[255:0];
    endfunction

    // -p^-1 mod 2^64 by Newton iteration.
    function automatic logic [63:0] nprime(input logic [63:0] pp);
        logic [63:0] inv;
        inv = pp;
        for (int k = 0; k < 6; k++) inv = inv * (64'd2 - pp * inv);
        return -inv;
    endfunction

    // Cycle model of the small instance: accept, fixed latency, one-cycle valid.
    always @(posedge clk) begin
        if (!reset_n || zeroize) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else if (m_busy) begin
            if (m_cnt == LAT1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == LAT1) begin
                    m_valid <= 1'b1;
                    m_res   <= m_pend;
                end
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_pend <= mont(256'(a), 256'(b), 256'(p), W1);
        end
    end

    // Per-cycle compare of the small instance against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("ready", 256'(ready), 256'(!m_busy));
            chk("valid", 256'(valid), 256'(m_valid));
            chk("result", 256'(result), m_res);
        end
    end

    task automatic launch(input logic [W1-1:0] aa, input logic [W1-1:0] bb);
        @(posedge clk); #1;
        a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~aa; b = ~bb;
    endtask

    task automatic wait_valid(input int from, output int lat);
        lat = 0;
        for (int k = from; k < from + 60; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic job(input logic [W1-1:0] aa, input logic [W1-1:0] bb,
                       input logic [W1-1:0] pp, input logic [R1-1:0] nn,
                       input logic [W1-1:0] exp, input string nm);
        int lat;
        p = pp; np = nn;
        launch(aa, bb);
        wait_valid(1, lat);
        chk({nm, "_lat"}, 256'(lat), 256'(LAT1));
        chk(nm, 256'(result), 256'(exp));
    endtask

    task automatic abort_test(input bit use_rst, input string nm);
        launch(16'h000F, 16'h1234);
        repeat (4) @(posedge clk);
        #1;
        if (use_rst) reset_n = 1'b0;
        else         zeroize = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1; zeroize = 1'b0;
        @(negedge clk);
        chk({nm, "_ready"}, 256'(ready), 256'(1));
        chk({nm, "_result"}, 256'(result), 256'(0));
        repeat (12) begin
            @(negedge clk);
            chk({nm, "_novalid"}, 256'(valid), 256'(0));
        end
        job(16'h000F, 16'h2222, 16'hFFF1, 8'hEF, 16'h2222, {nm, "_fresh"});
    endtask

    initial begin
        int lat1;
        int lat2;
        logic [63:0]  t64;
        logic [255:0] e;
        logic [W1-1:0] pp, aa, bb;
        logic [255:0] r;

        reset_n = 1'b0; zeroize = 1'b0; start = 1'b0;
        a = '0; b = '0; p = 16'hFFF1; np = 8'hEF;
        zeroize2 = 1'b0; start2 = 1'b0; a2 = '0; b2 = '0; p2 = '0; np2 = '0;

        chk("pin_id", mont(256'hF, 256'hF, 256'hFFF1, 16), 256'hF);
        chk("pin_conv", mont(256'hF, 256'h1234, 256'hFFF1, 16), 256'h1234);
        chk("pin_rinv", mont(256'hFFF0, 256'hFFF0, 256'hFFF1, 16), 256'hEEE1);
        t64 = nprime(64'hFFF1);
        chk("pin_np", 256'(t64[7:0]), 256'hEF);

        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 256'(ready), 256'(1));
        chk("rst_valid", 256'(valid), 256'(0));
        chk("rst_result", 256'(result), 256'(0));
        reset_n = 1'b1;

        job(16'h000F, 16'h000F, 16'hFFF1, 8'hEF, 16'h000F, "identity");
        job(16'h000F, 16'h1234, 16'hFFF1, 8'hEF, 16'h1234, "conv");
        job(16'h000F, 16'h0000, 16'hFFF1, 8'hEF, 16'h0000, "zero");
        job(16'hFFF0, 16'hFFF0, 16'hFFF1, 8'hEF, 16'hEEE1, "pm1");

        launch(16'h000F, 16'h0ABC);
        repeat (3) @(posedge clk);
        #1;
        a = 16'hFFF0; b = 16'hFFF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(5, lat1);
        chk("busy_lat", 256'(lat1), 256'(LAT1));
        chk("busy_result", 256'(result), 256'h0ABC);
        @(posedge clk); #1;
        a = 16'h000F; b = 16'h5555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(11, lat2);
        chk("b2b_gap", 256'(lat2 - lat1), 256'(10));
        chk("b2b_result", 256'(result), 256'h5555);

        abort_test(1'b0, "zeroize");
        abort_test(1'b1, "reset");

        for (int n = 0; n < 2000; n++) begin
            pp  = 16'($urandom_range(65535, 3)) | 16'h1;
            aa  = 16'($urandom % 32'(pp));
            bb  = 16'($urandom % 32'(pp));
            t64 = nprime(64'(pp));
            e   = mont(256'(aa), 256'(bb), 256'(pp), W1);
            job(aa, bb, pp, t64[7:0], e[15:0], "rand8");
        end

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
            r[255] = 1'b1;
            r[0]   = 1'b1;
            p2 = r;
            for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
            a2 = r % p2;
            for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
            b2 = r % p2;
            t64 = nprime(p2[63:0]);
            np2 = t64[31:0];
            e = mont(a2, b2, p2, W2);
            @(posedge clk); #1;
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            a2 = ~a2;
            lat2 = 0;
            for (int k = 1; k < 200; k++) begin
                @(negedge clk);
                if (valid2) begin
                    lat2 = k;
                    break;
                end
            end
            chk("rand32_lat", 256'(lat2), 256'(LAT2));
            chk("rand32", result2, e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
